// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout, fetches words into a FIFO and streams decoded pixels
// Ports: clk/rst (async active-high); start/continuous frame control;
//   mem_req/mem_addr/mem_ack/mem_rdata word read channel;
//   pix_valid/pix_ready/pix_rgb/pix_x/pix_y/pix_sof/pix_eol pixel stream;
//   busy/frame_done/frame_sum status. Define FB_SCANOUT_FRAME_SUM_EN for the frame_sum accumulator.
module fb_scanout #(
  parameter int          FB_WIDTH     = 320,
  parameter int          FB_HEIGHT    = 240,
  parameter logic [31:0] FB_BASE_ADDR = 32'h10000,
  parameter int          PIX_MODE     = 0,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] frame_sum
);
  localparam int NWORDS = PIX_MODE != 0 ? FB_WIDTH * FB_HEIGHT / 2 : FB_WIDTH * FB_HEIGHT;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, state_nxt;
  logic [31:0] word_idx;
  logic [31:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic half, wr, hs, pop, last_word, last_pix, start_ok;
  logic [31:0] word;
  logic [15:0] sub;
  logic [23:0] rgb565;
  assign start_ok = start && !frame_done;
  assign mem_req = state == REQ && count < (AW+1)'(FIFO_DEPTH);
  assign mem_addr = FB_BASE_ADDR + (word_idx << 2);
  assign wr = mem_req && mem_ack;
  assign pix_valid = count != '0;
  assign hs = pix_valid && pix_ready;
  assign pop = hs && (PIX_MODE == 0 || half);
  assign last_word = word_idx == 32'(NWORDS - 1);
  assign last_pix = hs && pix_x == 16'(FB_WIDTH - 1) && pix_y == 16'(FB_HEIGHT - 1);
  assign busy = state != IDLE || frame_done;
  assign word = fifo[rptr];
  // RGB565: even pixel in the upper half-word, odd pixel in the lower
  assign sub = half ? word[15:0] : word[31:16];
  assign rgb565 = {sub[15:11], sub[15:13], sub[10:5], sub[10:9], sub[4:0], sub[4:2]};
  assign pix_rgb = !pix_valid ? 24'd0 : PIX_MODE != 0 ? rgb565 : word[31:8];
  assign pix_sof = pix_valid && pix_x == 16'd0 && pix_y == 16'd0;
  assign pix_eol = pix_valid && pix_x == 16'(FB_WIDTH - 1);
  // continuous mode jumps straight back to REQ so the next frame's first
  // request overlaps the frame_done pulse
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_ok ? REQ : IDLE;
      REQ:     state_nxt = wr && last_word ? DRAIN : REQ;
      DRAIN:   state_nxt = last_pix ? (continuous ? REQ : IDLE) : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (wr) fifo[wptr] <= mem_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word_idx <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      half <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      frame_done <= last_pix;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr) begin
        wptr <= wptr + 1'b1;
        word_idx <= last_word ? '0 : word_idx + 32'd1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (hs && PIX_MODE != 0) half <= ~half;
      if (hs) begin
        pix_x <= pix_eol ? 16'd0 : pix_x + 16'd1;
        if (pix_eol) pix_y <= pix_y == 16'(FB_HEIGHT - 1) ? 16'd0 : pix_y + 16'd1;
      end
    end
  end
`ifdef FB_SCANOUT_FRAME_SUM_EN
  logic [31:0] sum;
  // the sof pixel restarts the sum so a continuous restart never loses the last pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else if (state == IDLE && start_ok) sum <= '0;
    else if (hs) sum <= (pix_sof ? 32'd0 : sum) + {8'h0, pix_rgb};
  end
  assign frame_sum = sum;
`else
  assign frame_sum = 32'd0;
`endif
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout (mode 0 depth 4 and mode 1 instances)
module tb_fb_scanout;
  typedef struct packed {logic [23:0] rgb; logic [15:0] x, y; logic sof, eol;} pix_t;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, cont0 = 1'b0, ready0 = 1'b1, ready1 = 1'b1;
  logic en0 = 1'b1, late0 = 1'b0;
  int pat = 0;
  logic req0, req1, ack0 = 1'b0, ack1 = 1'b0;
  logic [31:0] addr0, addr1, rdata0 = '0, rdata1 = '0, sum0, sum1;
  logic valid0, valid1, sof0, sof1, eol0, eol1, busy0, busy1, done0, done1;
  logic [23:0] rgbv0, rgbv1;
  logic [15:0] x0, y0, x1, y1;
  logic [31:0] addrs0[$];
  pix_t pix0[$], pix1[$];
  int dones0 = 0, dones1 = 0, reads1 = 0;
  int n_tests = 0, n_fail = 0;
`ifdef FB_SCANOUT_FRAME_SUM_EN
  localparam logic [31:0] SUM_A = 32'd8, SUM_B = 32'h00081018;
`else
  localparam logic [31:0] SUM_A = 32'd0, SUM_B = 32'd0;
`endif

  always #5 clk = ~clk;

  fb_scanout #(.FB_WIDTH(4), .FB_HEIGHT(2), .PIX_MODE(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .continuous(cont0),
    .mem_req(req0), .mem_addr(addr0), .mem_ack(ack0), .mem_rdata(rdata0),
    .pix_valid(valid0), .pix_ready(ready0), .pix_rgb(rgbv0), .pix_x(x0), .pix_y(y0),
    .pix_sof(sof0), .pix_eol(eol0), .busy(busy0), .frame_done(done0), .frame_sum(sum0));

  fb_scanout #(.FB_WIDTH(4), .FB_HEIGHT(2), .PIX_MODE(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .continuous(zero),
    .mem_req(req1), .mem_addr(addr1), .mem_ack(ack1), .mem_rdata(rdata1),
    .pix_valid(valid1), .pix_ready(ready1), .pix_rgb(rgbv1), .pix_x(x1), .pix_y(y1),
    .pix_sof(sof1), .pix_eol(eol1), .busy(busy1), .frame_done(done1), .frame_sum(sum1));

  always @(posedge clk) begin
    ack0 <= en0 ? (req0 && !ack0) : late0;
    rdata0 <= pat == 0 ? 32'h11223344 + ((addr0 - 32'h10000) >> 2) : pat == 1 ? 32'h000001FF : 32'h010203FF;
    ack1 <= req1 && !ack1;
    rdata1 <= 32'hF80007E0;
  end

  always @(negedge clk) begin
    if (req0 && ack0) addrs0.push_back(addr0);
    if (valid0 && ready0) pix0.push_back('{rgbv0, x0, y0, sof0, eol0});
    if (done0) dones0++;
    if (req1 && ack1) reads1++;
    if (valid1 && ready1) pix1.push_back('{rgbv1, x1, y1, sof1, eol1});
    if (done1) dones1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear();
    addrs0.delete();
    pix0.delete();
    pix1.delete();
    dones0 = 0;
    dones1 = 0;
    reads1 = 0;
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic wait_done0(input int n);
    for (int k = 0; k < 1000 && dones0 < n; k++) @(posedge clk);
    @(negedge clk);
    check("done_count0", 32'(dones0), 32'(n));
  endtask

  task automatic verify0(input int off);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("addr%0d", off + i), addrs0[off + i], 32'h10000 + 32'(4 * i));
      check($sformatf("rgb%0d", off + i), 32'(pix0[off + i].rgb), 32'h112233);
      check($sformatf("x%0d", off + i), 32'(pix0[off + i].x), 32'(i % 4));
      check($sformatf("y%0d", off + i), 32'(pix0[off + i].y), 32'(i / 4));
      check($sformatf("sof%0d", off + i), 32'(pix0[off + i].sof), 32'(i == 0));
      check($sformatf("eol%0d", off + i), 32'(pix0[off + i].eol), 32'(i % 4 == 3));
    end
  endtask

  initial begin
    @(negedge clk);
    check("rst_req", 32'(req0), 0);
    check("rst_addr", addr0, 32'h10000);
    check("rst_valid", 32'(valid0), 0);
    check("rst_rgb", 32'(rgbv0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_sum", sum0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // basic mode 0 frame
    clear();
    pulse0();
    @(negedge clk);
    check("first_req", 32'(req0), 1);
    check("first_busy", 32'(busy0), 1);
    check("first_addr", addr0, 32'h10000);
    @(negedge clk);
    check("valid_in_ack_cycle", 32'(valid0), 0);
    @(negedge clk);
    check("valid_after_ack", 32'(valid0), 1);
    wait_done0(1);
    repeat (5) @(posedge clk);
    #1;
    check("a_reads", 32'(addrs0.size()), 8);
    check("a_pixels", 32'(pix0.size()), 8);
    check("a_busy_end", 32'(busy0), 0);
    check("a_single_done", 32'(dones0), 1);
    verify0(0);
    // mode 1 frame
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 0; k < 1000 && dones1 < 1; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("b_done", 32'(dones1), 1);
    check("b_reads", 32'(reads1), 4);
    check("b_pixels", 32'(pix1.size()), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("m1_rgb%0d", i), 32'(pix1[i].rgb), (i % 2) != 0 ? 32'h00FF00 : 32'hFF0000);
      check($sformatf("m1_x%0d", i), 32'(pix1[i].x), 32'(i % 4));
    end
    // backpressure with a full FIFO
    clear();
    ready0 = 1'b0;
    pulse0();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_rgb_early", 32'(rgbv0), 32'h112233);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp_reads", 32'(addrs0.size()), 4);
    check("bp_req_low", 32'(req0), 0);
    check("bp_valid", 32'(valid0), 1);
    check("bp_rgb_late", 32'(rgbv0), 32'h112233);
    check("bp_x", 32'(x0), 0);
    check("bp_sof", 32'(sof0), 1);
    @(posedge clk);
    #1 ready0 = 1'b1;
    wait_done0(1);
    check("bp_pixels", 32'(pix0.size()), 8);
    verify0(0);
    // continuous restart, extra start while busy
    repeat (3) @(posedge clk);
    #1;
    clear();
    cont0 = 1'b1;
    pulse0();
    repeat (5) @(posedge clk);
    #1;
    pulse0();
    for (int k = 0; k < 1000 && !done0; k++) @(negedge clk);
    check("cont_done_seen", 32'(done0), 1);
    check("cont_req", 32'(req0), 1);
    check("cont_addr", addr0, 32'h10000);
    check("cont_busy", 32'(busy0), 1);
    cont0 = 1'b0;
    wait_done0(2);
    repeat (3) @(posedge clk);
    #1;
    check("cont_reads", 32'(addrs0.size()), 16);
    check("cont_pixels", 32'(pix0.size()), 16);
    verify0(0);
    verify0(8);
    // reset mid-request, late ack
    clear();
    pulse0();
    @(negedge clk);
    check("r_req_before", 32'(req0), 1);
    rst = 1'b1;
    #1;
    check("r_req", 32'(req0), 0);
    check("r_addr", addr0, 32'h10000);
    check("r_busy", 32'(busy0), 0);
    check("r_valid", 32'(valid0), 0);
    check("r_x", 32'(x0), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en0 = 1'b0;
    late0 = 1'b1;
    @(posedge clk);
    #1 late0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("r_late_req", 32'(req0), 0);
    check("r_late_valid", 32'(valid0), 0);
    check("r_late_busy", 32'(busy0), 0);
    check("r_late_reads", 32'(addrs0.size()), 0);
    check("r_late_pix", 32'(pix0.size()), 0);
    en0 = 1'b1;
    // frame sum
    @(posedge clk);
    #1;
    clear();
    pat = 1;
    pulse0();
    wait_done0(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sum_a", sum0, SUM_A);
    @(posedge clk);
    #1;
    pat = 2;
    pulse0();
    @(negedge clk);
    check("sum_cleared", sum0, 0);
    wait_done0(2);
    check("sum_b", sum0, SUM_B);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sum_b_held", sum0, SUM_B);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
